// File: rtl/poly_ram_pkg.sv
// poly_ram_pkg: shared arbiter state encoding and requester-index type.
package poly_ram_pkg;

  localparam int unsigned REQ_IDX_W = 1;

  typedef logic [REQ_IDX_W-1:0] req_idx_t;

  localparam req_idx_t REQ0 = 1'b0;
  localparam req_idx_t REQ1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/poly_ram_arbiter.sv
// poly_ram_arbiter: two-requester round-robin arbiter in front of one RAM port.
// Ownership locks with a LOCK_MAX cycle limit are built only with POLY_ARB_LOCK_EN.
module poly_ram_arbiter
  import poly_ram_pkg::*;
#(
  parameter  int unsigned MEM_WIDTH = 8,
  parameter  int unsigned MEM_SIZE  = 896,
  parameter  int unsigned LOCK_MAX  = 64,
  localparam int unsigned ADDR_W    = $clog2(MEM_SIZE)
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic                 req_valid_0,
  input  logic                 req_we_0,
  input  logic [ADDR_W-1:0]    req_addr_0,
  input  logic [MEM_WIDTH-1:0] req_wdata_0,
  input  logic                 req_lock_0,
  output logic                 req_ready_0,
  output logic                 rsp_valid_0,
  output logic [MEM_WIDTH-1:0] rsp_data_0,

  input  logic                 req_valid_1,
  input  logic                 req_we_1,
  input  logic [ADDR_W-1:0]    req_addr_1,
  input  logic [MEM_WIDTH-1:0] req_wdata_1,
  input  logic                 req_lock_1,
  output logic                 req_ready_1,
  output logic                 rsp_valid_1,
  output logic [MEM_WIDTH-1:0] rsp_data_1,

  output logic                 ram_en,
  output logic                 ram_we,
  output logic [ADDR_W-1:0]    ram_addr,
  output logic [MEM_WIDTH-1:0] ram_di,
  input  logic [MEM_WIDTH-1:0] ram_do
);

  arb_state_t           state, state_d;
  req_idx_t             last_gnt, gnt_idx, rd_tag;
  logic                 gnt_vld, gnt_we;
  logic                 rd_pend, rsp_hit_0, rsp_hit_1;
  logic                 lock_expired;
  logic [MEM_WIDTH-1:0] data_q_0, data_q_1;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

`ifdef POLY_ARB_LOCK_EN
  localparam int unsigned CNT_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;

  logic [CNT_W-1:0] lock_cnt;
  logic             gnt_lock;

  // Next-state logic
  always_comb begin
    gnt_lock     = (gnt_idx == REQ1) ? req_lock_1 : req_lock_0;
    lock_expired = (state != IDLE) && (lock_cnt == CNT_W'(LOCK_MAX - 1));
    state_d      = state;
    case (state)
      IDLE:       if (gnt_vld && gnt_lock) state_d = (gnt_idx == REQ1) ? OWN1 : OWN0;
      OWN0, OWN1: if (lock_expired || (gnt_vld && !gnt_lock)) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Counts cycles spent owned; cleared whenever ownership is absent or ending.
  always_ff @(posedge clk) begin
    if (rst || state == IDLE || state_d == IDLE) lock_cnt <= '0;
    else                                         lock_cnt <= lock_cnt + CNT_W'(1);
  end
`else
  logic [33:0] unused_lock;

  always_comb begin
    state_d      = IDLE;
    lock_expired = 1'b0;
    unused_lock  = {req_lock_0, req_lock_1, 32'(LOCK_MAX)};
  end
`endif

  // Output logic: grant selection, RAM drive and response presentation
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = REQ0;
    if (!rst) begin
      case (state)
        OWN0: gnt_vld = req_valid_0;
        OWN1: begin
          gnt_vld = req_valid_1;
          gnt_idx = REQ1;
        end
        default: begin
          if (req_valid_0 && req_valid_1) begin
            gnt_vld = 1'b1;
            gnt_idx = (last_gnt == REQ0) ? REQ1 : REQ0;
          end else if (req_valid_0) begin
            gnt_vld = 1'b1;
          end else if (req_valid_1) begin
            gnt_vld = 1'b1;
            gnt_idx = REQ1;
          end
        end
      endcase
    end

    gnt_we      = (gnt_idx == REQ1) ? req_we_1 : req_we_0;
    req_ready_0 = gnt_vld && (gnt_idx == REQ0);
    req_ready_1 = gnt_vld && (gnt_idx == REQ1);
    ram_en      = gnt_vld;
    ram_we      = gnt_vld && gnt_we;
    ram_addr    = (gnt_idx == REQ1) ? req_addr_1  : req_addr_0;
    ram_di      = (gnt_idx == REQ1) ? req_wdata_1 : req_wdata_0;

    // ram_do is live the cycle after the read; the held copy covers idle cycles.
    rsp_hit_0   = !rst && rd_pend && (rd_tag == REQ0);
    rsp_hit_1   = !rst && rd_pend && (rd_tag == REQ1);
    rsp_valid_0 = rsp_hit_0;
    rsp_valid_1 = rsp_hit_1;
    rsp_data_0  = rst ? '0 : (rsp_hit_0 ? ram_do : data_q_0);
    rsp_data_1  = rst ? '0 : (rsp_hit_1 ? ram_do : data_q_1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt <= REQ1;
      rd_pend  <= 1'b0;
      rd_tag   <= REQ0;
      data_q_0 <= '0;
      data_q_1 <= '0;
    end else begin
      if (gnt_vld)           last_gnt <= gnt_idx;
      else if (lock_expired) last_gnt <= (state == OWN1) ? REQ1 : REQ0;
      rd_pend <= gnt_vld && !gnt_we;
      if (gnt_vld && !gnt_we) rd_tag <= gnt_idx;
      if (rsp_hit_0) data_q_0 <= ram_do;
      if (rsp_hit_1) data_q_1 <= ram_do;
    end
  end

endmodule

// File: tb/tb_poly_ram_arbiter.sv
// tb_poly_ram_arbiter: scoreboard bench with a behavioural RAM and arbitration
// model; lock scenarios run only when POLY_ARB_LOCK_EN is defined.
module tb_poly_ram_arbiter;

  localparam int unsigned MEM_WIDTH = 8;
  localparam int unsigned MEM_SIZE  = 896;
  localparam int unsigned LOCK_MAX  = 4;
  localparam int unsigned ADDR_W    = $clog2(MEM_SIZE);
`ifdef POLY_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                 v  [2];
  logic                 we [2];
  logic                 lk [2];
  logic [ADDR_W-1:0]    ad [2];
  logic [MEM_WIDTH-1:0] wd [2];

  logic                 req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1;
  logic [MEM_WIDTH-1:0] rsp_data_0, rsp_data_1;
  logic                 ram_en, ram_we;
  logic [ADDR_W-1:0]    ram_addr;
  logic [MEM_WIDTH-1:0] ram_di, ram_do;

  poly_ram_arbiter #(
    .MEM_WIDTH(MEM_WIDTH),
    .MEM_SIZE (MEM_SIZE),
    .LOCK_MAX (LOCK_MAX)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid_0(v[0]),
    .req_we_0   (we[0]),
    .req_addr_0 (ad[0]),
    .req_wdata_0(wd[0]),
    .req_lock_0 (lk[0]),
    .req_ready_0(req_ready_0),
    .rsp_valid_0(rsp_valid_0),
    .rsp_data_0 (rsp_data_0),
    .req_valid_1(v[1]),
    .req_we_1   (we[1]),
    .req_addr_1 (ad[1]),
    .req_wdata_1(wd[1]),
    .req_lock_1 (lk[1]),
    .req_ready_1(req_ready_1),
    .rsp_valid_1(rsp_valid_1),
    .rsp_data_1 (rsp_data_1),
    .ram_en     (ram_en),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_di     (ram_di),
    .ram_do     (ram_do)
  );

  function automatic logic [MEM_WIDTH-1:0] init_val(input int a);
    return MEM_WIDTH'((a * 29 + 7) ^ (a >> 3));
  endfunction

  // Synchronous-read RAM; untouched words read back as init_val.
  logic [MEM_WIDTH-1:0] ram    [MEM_SIZE];
  bit                   ram_wr [MEM_SIZE];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        ram[ram_addr]    <= ram_di;
        ram_wr[ram_addr] <= 1'b1;
      end else begin
        ram_do <= ram_wr[ram_addr] ? ram[ram_addr] : init_val(int'(ram_addr));
      end
    end
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int                   req;
    logic [MEM_WIDTH-1:0] data;
    int                   due;
  } exp_item_t;

  exp_item_t            exp_q[$];
  logic [MEM_WIDTH-1:0] ref_mem [int];
  int                   owner = -1;
  int                   last  = 1;
  int                   held  = 0;

  function automatic logic [MEM_WIDTH-1:0] mem_val(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  function automatic int exp_grant();
    if (rst) return -1;
    if (owner >= 0) return v[owner] ? owner : -1;
    if (v[0] && v[1]) return 1 - last;
    if (v[0]) return 0;
    if (v[1]) return 1;
    return -1;
  endfunction

  // Reference model: expected grant/RAM drive this cycle, then advance its state.
  always @(negedge clk) begin : model
    int g;
    g = exp_grant();
    check("ready_0", req_ready_0, g == 0);
    check("ready_1", req_ready_1, g == 1);
    check("ram_en", ram_en, g >= 0);
    if (g >= 0) begin
      check("ram_we", ram_we, we[g]);
      check("ram_addr", ram_addr, ad[g]);
      if (we[g]) check("ram_di", ram_di, wd[g]);
    end else begin
      check("ram_we_idle", ram_we, 0);
    end

    if (rst) begin
      owner = -1;
      last  = 1;
      held  = 0;
    end else begin
      if (g >= 0) begin
        last = g;
        if (we[g]) ref_mem[int'(ad[g])] = wd[g];
        else exp_q.push_back('{req: g, data: mem_val(int'(ad[g])), due: cyc + 1});
      end
      if (LOCK_EN) begin
        if (owner >= 0) begin
          held++;
          if (held == int'(LOCK_MAX)) begin
            last  = owner;
            owner = -1;
          end else if (g == owner && !lk[g]) begin
            owner = -1;
          end
        end else if (g >= 0 && lk[g]) begin
          owner = g;
          held  = 0;
        end
      end
    end
  end

  // Response monitor: pops the scoreboard whenever a response is presented.
  logic [MEM_WIDTH-1:0] last_data [2] = '{default: '0};
  always @(negedge clk) begin : monitor
    exp_item_t it;
    if (rst) begin
      check("rst_rsp_valid_0", rsp_valid_0, 0);
      check("rst_rsp_valid_1", rsp_valid_1, 0);
      check("rst_rsp_data_0", rsp_data_0, 0);
      check("rst_rsp_data_1", rsp_data_1, 0);
      exp_q.delete();
      last_data[0] = '0;
      last_data[1] = '0;
    end else begin
      if (rsp_valid_0 || rsp_valid_1) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 1, 0);
        end else begin
          it = exp_q.pop_front();
          check("rsp_cycle", cyc, it.due);
          check("rsp_valid_0", rsp_valid_0, it.req == 0);
          check("rsp_valid_1", rsp_valid_1, it.req == 1);
          check("rsp_data", (it.req == 0) ? rsp_data_0 : rsp_data_1, it.data);
          last_data[it.req] = it.data;
        end
      end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        it = exp_q.pop_front();
        check("rsp_missing", 0, 1);
      end
      if (!rsp_valid_0) check("hold_data_0", rsp_data_0, last_data[0]);
      if (!rsp_valid_1) check("hold_data_1", rsp_data_1, last_data[1]);
    end
  end

  task automatic drive(input int i, input logic vv, input logic wwe, input int a,
                       input int d, input logic l);
    v[i]  = vv;
    we[i] = wwe;
    ad[i] = ADDR_W'(a);
    wd[i] = MEM_WIDTH'(d);
    lk[i] = l;
  endtask

  task automatic idle_all();
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle_all();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;

    // Contending reads alternate, requester 0 first after reset
    drive(0, 1, 0, 5, 0, 0);
    drive(1, 1, 0, 9, 0, 0);
    repeat (4) step();
    idle_all();
    step();

    // Write from 0 then read of the same word by 1
    drive(0, 1, 1, 12, 8'hA5, 0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 12, 0, 0);
    step();
    idle_all();
    repeat (2) step();

    // Read squashed by reset the following cycle, then contention
    drive(0, 1, 0, 3, 0, 0);
    step();
    idle_all();
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(0, 1, 0, 7, 0, 0);
    drive(1, 1, 0, 8, 0, 0);
    repeat (2) step();
    idle_all();
    step();

`ifdef POLY_ARB_LOCK_EN
    drive(1, 1, 0, 40, 0, 1);
    step();
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 41, 0, 0);
    repeat (3) step();
    drive(1, 1, 1, 42, 8'h3C, 0);
    step();
    drive(1, 0, 0, 0, 0, 0);
    repeat (2) step();
    idle_all();
    step();

    drive(0, 1, 0, 50, 0, 1);
    drive(1, 1, 0, 51, 0, 0);
    repeat (8) step();
    idle_all();
    step();
`endif

    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 2; i++) begin
        drive(i, $urandom_range(0, 99) < 60, $urandom_range(0, 1),
              ($urandom_range(0, 1) != 0) ? $urandom_range(0, 15) : $urandom_range(0, MEM_SIZE - 1),
              $urandom_range(0, 255), $urandom_range(0, 99) < 15);
      end
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0;
    idle_all();
    repeat (4) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
